// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped 2-bit counter table plus BTB, with a
// registered one-cycle lookup, execute-stage training and mispredict statistics.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_req_i,
  input  logic [31:0] pred_pc_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][1:0]        ctr;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag;
  logic [ENTRIES-1:0][31:0]       target;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, l_taken, u_hit, mispredict;
  logic [1:0]       ctr_cur, ctr_nxt;
  logic [31:0]      br_cnt, mispred_cnt;

  assign l_idx   = pred_pc_i[IDX_W+1:2];
  assign l_tag   = pred_pc_i[31:IDX_W+2];
  assign u_idx   = upd_pc_i[IDX_W+1:2];
  assign u_tag   = upd_pc_i[31:IDX_W+2];
  assign l_hit   = valid[l_idx] && (tag[l_idx] == l_tag);
  assign l_taken = l_hit && ctr[l_idx][1];
  assign u_hit   = valid[u_idx] && (tag[u_idx] == u_tag);
  assign ctr_cur = ctr[u_idx];

  // Not-taken target mismatch is irrelevant: fall-through is the only next PC.
  assign mispredict = (upd_taken_i != upd_pred_taken_i) ||
                      (upd_taken_i && (upd_pred_target_i != upd_target_i));

  always_comb begin
    ctr_nxt = ctr_cur;
    if (!u_hit)
      ctr_nxt = 2'b10;
    else if (upd_taken_i) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  // A miss that resolves not-taken leaves the table alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      ctr   <= {ENTRIES{2'b01}};
    end else if (upd_valid_i && (u_hit || upd_taken_i)) begin
      valid[u_idx] <= 1'b1;
      ctr[u_idx]   <= ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && upd_valid_i && upd_taken_i) begin
      tag[u_idx]    <= u_tag;
      target[u_idx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_o  <= 1'b0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= '0;
    end else begin
      pred_valid_o <= pred_req_i;
      if (pred_req_i) begin
        pred_taken_o  <= l_taken;
        pred_target_o <= l_taken ? target[l_idx] : pred_pc_i + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_o <= 1'b0;
      br_cnt       <= '0;
      mispred_cnt  <= '0;
    end else begin
      mispredict_o <= upd_valid_i && mispredict;
      if (upd_valid_i && (br_cnt != '1)) br_cnt <= br_cnt + 32'd1;
      if (upd_valid_i && mispredict && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign br_cnt_o      = br_cnt;
  assign mispred_cnt_o = mispred_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic checked
// against a table-of-counters reference model.
module tb_branch_predictor;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req_i;
  logic [31:0] pred_pc_i;
  logic        pred_valid_o, pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i, upd_taken_i, upd_pred_taken_i;
  logic [31:0] upd_pc_i, upd_target_i, upd_pred_target_i;
  logic        mispredict_o;
  logic [31:0] br_cnt_o, mispred_cnt_o;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .mispredict_o(mispredict_o), .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: per-entry state and expected registered outputs
  bit          m_valid [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic        e_pv, e_pt, e_mis;
  logic [31:0] e_ptgt, e_br, e_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & (ENTRIES - 1));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic cycle(input bit r, input bit req, input logic [31:0] pc,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
    int li, ui;
    bit lhit, uhit;
    rst = r; pred_req_i = req; pred_pc_i = pc;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
    upd_pred_taken_i = upt; upd_pred_target_i = uptgt;
    li = idx_of(pc);
    lhit = m_valid[li] && (m_tag[li] == tag_of(pc));
    ui = idx_of(upc);
    uhit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
    @(posedge clk); #1;
    if (r) begin
      for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
      e_pv = 0; e_pt = 0; e_ptgt = 0; e_mis = 0; e_br = 0; e_mc = 0;
    end else begin
      e_pv = req;
      if (req) begin
        e_pt = lhit && (m_ctr[li] >= 2);
        e_ptgt = e_pt ? m_tgt[li] : pc + 32'd4;
      end
      e_mis = uv && ((ut != upt) || (ut && (uptgt != utgt)));
      if (uv) begin
        if (e_br != 32'hFFFF_FFFF) e_br = e_br + 1;
        if (e_mis && e_mc != 32'hFFFF_FFFF) e_mc = e_mc + 1;
        if (uhit) begin
          m_ctr[ui] = ut ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                         : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
          if (ut) m_tgt[ui] = utgt;
        end else if (ut) begin
          m_valid[ui] = 1; m_tag[ui] = tag_of(upc); m_tgt[ui] = utgt; m_ctr[ui] = 2;
        end
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic look(input logic [31:0] pc);
    cycle(0, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                     input bit pt, input logic [31:0] ptgt);
    cycle(0, 0, 0, 1, pc, t, tgt, pt, ptgt);
  endtask

  task automatic test_reset();
    cycle(1, 1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({pred_valid_o, pred_taken_o, pred_target_o, mispredict_o} !== 35'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b/%b/%h/%b want 0/0/0/0",
                         pred_valid_o, pred_taken_o, pred_target_o, mispredict_o);
    end
    n_chk++;
    if ({br_cnt_o, mispred_cnt_o} !== 64'd0) begin
      n_fail++; $display("FAIL reset_counts: got %h/%h want 0/0", br_cnt_o, mispred_cnt_o);
    end
  endtask

  task automatic test_basic();
    look(32'h100);
    n_chk++;
    if ({pred_valid_o, pred_taken_o, pred_target_o} !== {2'b10, 32'h104}) begin
      n_fail++; $display("FAIL basic_lookup: got %b/%b/%h want 1/0/00000104",
                         pred_valid_o, pred_taken_o, pred_target_o);
    end
    n_chk++;
    if (br_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL basic_brcnt: got %h want 0", br_cnt_o);
    end
    idle();
    n_chk++;
    if ({pred_valid_o, pred_target_o} !== {1'b0, 32'h104}) begin
      n_fail++; $display("FAIL basic_hold: got %b/%h want 0/00000104", pred_valid_o, pred_target_o);
    end
  endtask

  task automatic test_alloc();
    upd(32'h100, 1, 32'h200, 0, 32'h104);
    n_chk++;
    if (mispredict_o !== 1'b1) begin
      n_fail++; $display("FAIL alloc_mispredict: got %b want 1", mispredict_o);
    end
    look(32'h100);
    n_chk++;
    if ({mispredict_o, pred_valid_o, pred_taken_o, pred_target_o} !== {3'b011, 32'h200}) begin
      n_fail++; $display("FAIL alloc_lookup: got mis=%b %b/%b/%h want 0 1/1/00000200",
                         mispredict_o, pred_valid_o, pred_taken_o, pred_target_o);
    end
    n_chk++;
    if ({br_cnt_o, mispred_cnt_o} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL alloc_counts: got %h/%h want 1/1", br_cnt_o, mispred_cnt_o);
    end
  endtask

  task automatic test_counter();
    for (int i = 0; i < 4; i++) upd(32'h100, 0, 32'h200, 1, 32'h200);
    look(32'h100);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b0, 32'h104}) begin
      n_fail++; $display("FAIL ctr_down: got %b/%h want 0/00000104", pred_taken_o, pred_target_o);
    end
    upd(32'h100, 1, 32'h200, 0, 32'h104);
    look(32'h100);
    n_chk++;
    if (pred_taken_o !== 1'b0) begin
      n_fail++; $display("FAIL ctr_weak_nt: got %b want 0", pred_taken_o);
    end
    upd(32'h100, 1, 32'h200, 0, 32'h104);
    look(32'h100);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b1, 32'h200}) begin
      n_fail++; $display("FAIL ctr_up: got %b/%h want 1/00000200", pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_alias();
    logic [31:0] al;
    al = 32'h100 + 4 * ENTRIES;
    look(al);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b0, al + 32'd4}) begin
      n_fail++; $display("FAIL alias_miss: got %b/%h want 0/%h", pred_taken_o, pred_target_o, al + 32'd4);
    end
    upd(al, 1, 32'h400, 0, al + 32'd4);
    look(32'h100);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b0, 32'h104}) begin
      n_fail++; $display("FAIL alias_evict: got %b/%h want 0/00000104", pred_taken_o, pred_target_o);
    end
    look(al);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b1, 32'h400}) begin
      n_fail++; $display("FAIL alias_hit: got %b/%h want 1/00000400", pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_same_cycle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b0, 32'h104}) begin
      n_fail++; $display("FAIL rbw_same: got %b/%h want 0/00000104", pred_taken_o, pred_target_o);
    end
    look(32'h100);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b1, 32'h200}) begin
      n_fail++; $display("FAIL rbw_next: got %b/%h want 1/00000200", pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, upc, tgt, ptgt;
    bit t, pt;
    for (int n = 0; n < 400; n++) begin
      pc  = 32'h1000 + 4 * $urandom_range(0, 11) + ($urandom_range(0, 3) == 0 ? 4 * ENTRIES : 0);
      upc = 32'h1000 + 4 * $urandom_range(0, 11) + ($urandom_range(0, 3) == 0 ? 4 * ENTRIES : 0);
      tgt = 32'h8000 + 4 * $urandom_range(0, 3);
      t   = $urandom_range(0, 2) != 0;
      pt  = $urandom_range(0, 1);
      ptgt = $urandom_range(0, 1) ? tgt : upc + 32'd4;
      cycle(0, $urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0, upc, t, tgt, pt, ptgt);
      n_chk++;
      if ({pred_valid_o, pred_taken_o, pred_target_o, mispredict_o, br_cnt_o, mispred_cnt_o} !==
          {e_pv, e_pt, e_ptgt, e_mis, e_br, e_mc}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b/%b/%h/%b/%h/%h want %b/%b/%h/%b/%h/%h", n,
                 pred_valid_o, pred_taken_o, pred_target_o, mispredict_o, br_cnt_o, mispred_cnt_o,
                 e_pv, e_pt, e_ptgt, e_mis, e_br, e_mc);
      end
    end
  endtask

  task automatic test_saturate();
    force dut.br_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt;
    e_br = 32'hFFFF_FFFE;
    upd(32'h100, 0, 0, 0, 0);
    n_chk++;
    if (br_cnt_o !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat_reach: got %h want ffffffff", br_cnt_o);
    end
    upd(32'h100, 0, 0, 0, 0);
    upd(32'h104, 1, 32'h10, 1, 32'h10);
    n_chk++;
    if (br_cnt_o !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat_hold: got %h want ffffffff", br_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    upd(32'h100, 1, 32'h200, 0, 32'h104);
    cycle(1, 1, 32'h100, 1, 32'h300, 1, 32'h500, 0, 32'h304);
    n_chk++;
    if ({pred_valid_o, pred_taken_o, pred_target_o, mispredict_o, br_cnt_o, mispred_cnt_o} !== 99'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b/%b/%h/%b/%h/%h want all 0",
                         pred_valid_o, pred_taken_o, pred_target_o, mispredict_o, br_cnt_o, mispred_cnt_o);
    end
    look(32'h300);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b0, 32'h304}) begin
      n_fail++; $display("FAIL rstmid_discard: got %b/%h want 0/00000304", pred_taken_o, pred_target_o);
    end
    look(32'h100);
    n_chk++;
    if ({pred_taken_o, pred_target_o} !== {1'b0, 32'h104}) begin
      n_fail++; $display("FAIL rstmid_cleared: got %b/%h want 0/00000104", pred_taken_o, pred_target_o);
    end
  endtask

  initial begin
    rst = 1; pred_req_i = 0; pred_pc_i = 0; upd_valid_i = 0; upd_pc_i = 0;
    upd_taken_i = 0; upd_target_i = 0; upd_pred_taken_i = 0; upd_pred_target_i = 0;
    test_reset();
    test_basic();
    test_alloc();
    test_counter();
    test_alias();
    test_same_cycle();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
